fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_if.sv | 26 ++
 rtl/fetch_stage.sv | 92 +++++++++
 tb/tb_fetch_stage.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus bundle: control in, instruction memory port, decode output.
// master = the fetch stage itself; slave = the environment driving it.
interface fetch_stage_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic [31:0] next_pc;

  modport master (
    input  redirect_valid, redirect_pc, halt, imem_ack, imem_rdata, out_ready,
    output imem_req, imem_addr, out_valid, instr_out, pc_out, next_pc
  );

  modport slave (
    output redirect_valid, redirect_pc, halt, imem_ack, imem_rdata, out_ready,
    input  imem_req, imem_addr, out_valid, instr_out, pc_out, next_pc
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage with one-entry output hold register, redirect and halt.
// Optional FETCH_STALL_CNT_EN adds a saturating decode-stall cycle counter (stall_cnt).
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  fetch_stage_if.master     bus
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] FETCH  = 2'd1;
  localparam logic [1:0] HALTED = 2'd2;

  logic [1:0]  state_reg;
  logic [1:0]  state_next;
  logic [31:0] pc_reg;
  logic        out_valid_reg;
  logic [31:0] instr_reg;
  logic [31:0] pc_out_reg;
  logic [31:0] next_pc_reg;
  logic        accept;
  logic [31:0] pc_plus4;

  // Only request when the hold register is empty or being drained this cycle.
  assign bus.imem_req  = (state_reg == FETCH) && (!out_valid_reg || bus.out_ready);
  assign bus.imem_addr = pc_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.instr_out = instr_reg;
  assign bus.pc_out    = pc_out_reg;
  assign bus.next_pc   = next_pc_reg;

  assign accept   = bus.imem_req && bus.imem_ack;
  assign pc_plus4 = pc_reg + 32'd4;

  // Redirect never changes the state transition: IDLE always completes,
  // elsewhere halt alone chooses between FETCH and HALTED.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    state_next = FETCH;
      FETCH:   if (bus.halt) state_next = HALTED;
      HALTED:  if (!bus.halt) state_next = FETCH;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      pc_reg        <= RESET_PC;
      out_valid_reg <= 1'b0;
      instr_reg     <= 32'd0;
      pc_out_reg    <= 32'd0;
      next_pc_reg   <= 32'd0;
    end else begin
      state_reg <= state_next;
      if (bus.redirect_valid) begin
        // Any same-cycle ack is dropped; the held instruction is squashed.
        pc_reg        <= bus.redirect_pc;
        out_valid_reg <= 1'b0;
      end else if (accept) begin
        instr_reg     <= bus.imem_rdata;
        pc_out_reg    <= pc_reg;
        next_pc_reg   <= pc_plus4;
        out_valid_reg <= 1'b1;
        pc_reg        <= pc_plus4;
      end else if (out_valid_reg && bus.out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

`ifdef FETCH_STALL_CNT_EN
  logic [31:0] stall_cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_reg <= 32'd0;
    end else if (out_valid_reg && !bus.out_ready && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed + randomized bench for fetch_stage against a behavioural model.
// Build with +define+FETCH_STALL_CNT_EN to also check the stall counter.
module tb_fetch_stage;

  localparam logic [31:0] RPC = 32'h0000_0100;

  logic clk = 1'b0;
  logic rst;
  fetch_stage_if bus();
`ifdef FETCH_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  fetch_stage #(.RESET_PC(RPC)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef FETCH_STALL_CNT_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  // Behavioural model: "still in the post-reset cycle", "halted", the PC,
  // and the slot seen by decode.
  bit          m_idle;
  bit          m_halted;
  logic [31:0] m_pc;
  bit          m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_pco;
  logic [31:0] m_npc;
  longint      m_stall;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit m_req(input bit rdy);
    return !m_idle && !m_halted && (!m_valid || rdy);
  endfunction

  task automatic model_reset();
    m_idle = 1'b1; m_halted = 1'b0; m_pc = RPC; m_valid = 1'b0;
    m_instr = 32'd0; m_pco = 32'd0; m_npc = 32'd0; m_stall = 0;
  endtask

  task automatic check_all();
    chk("imem_req", {31'd0, bus.imem_req}, {31'd0, m_req(bus.out_ready)});
    chk("imem_addr", bus.imem_addr, m_pc);
    chk("out_valid", {31'd0, bus.out_valid}, {31'd0, m_valid});
    chk("instr_out", bus.instr_out, m_instr);
    chk("pc_out", bus.pc_out, m_pco);
    chk("next_pc", bus.next_pc, m_npc);
`ifdef FETCH_STALL_CNT_EN
    chk("stall_cnt", stall_cnt, 32'(m_stall));
`endif
  endtask

  // One clock: drive at negedge, compare, then advance the model at posedge.
  task automatic cycle(input bit rv, input logic [31:0] rpc, input bit h,
                       input bit ack, input bit rdy);
    logic [31:0] rd;
    bit          req;
    @(negedge clk);
    rd = $urandom;
    bus.redirect_valid = rv; bus.redirect_pc = rpc; bus.halt = h;
    bus.imem_ack = ack; bus.imem_rdata = rd; bus.out_ready = rdy;
    #1 check_all();
    @(posedge clk);
    req = m_req(rdy);
    if (m_valid && !rdy && m_stall < 64'hFFFF_FFFF) m_stall++;
    if (m_idle) m_idle = 1'b0;
    else m_halted = h;
    if (rv) begin
      m_pc = rpc; m_valid = 1'b0;
    end else if (req && ack) begin
      m_instr = rd; m_pco = m_pc;
      m_npc = 32'((longint'(m_pc) + 4) % 64'h1_0000_0000);
      m_pc = m_npc; m_valid = 1'b1;
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
  endtask

  // Asserts rst mid-cycle, checks the immediate effect, releases after a posedge.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_imem_req", {31'd0, bus.imem_req}, 32'd0);
    chk("rst_instr", bus.instr_out, 32'd0);
    chk("rst_pc_out", bus.pc_out, 32'd0);
    chk("rst_next_pc", bus.next_pc, 32'd0);
    chk("rst_imem_addr", bus.imem_addr, RPC);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
  endtask

  initial begin
    logic [31:0] s0;
    logic [31:0] r;
    s0 = 32'd0;
    rst = 1'b1;
    bus.redirect_valid = 1'b0; bus.redirect_pc = 32'd0; bus.halt = 1'b0;
    bus.imem_ack = 1'b0; bus.imem_rdata = 32'd0; bus.out_ready = 1'b0;
    @(posedge clk);
    do_reset();

    // Sequential fetch from RESET_PC after one IDLE cycle.
    cycle(0, 0, 0, 1, 1);
    #1 chk("idle_addr", bus.imem_addr, RPC);
    cycle(0, 0, 0, 1, 1);
    #1 chk("seq_pc0", bus.pc_out, 32'h100); chk("seq_npc0", bus.next_pc, 32'h104);
    cycle(0, 0, 0, 1, 1);
    #1 chk("seq_pc1", bus.pc_out, 32'h104);
    cycle(0, 0, 0, 1, 1);
    #1 chk("seq_pc2", bus.pc_out, 32'h108); chk("seq_npc2", bus.next_pc, 32'h10C);

    // Decode stall for three cycles: outputs frozen, no requests.
`ifdef FETCH_STALL_CNT_EN
    s0 = stall_cnt;
`endif
    repeat (3) cycle(0, 0, 0, 1, 0);
    #1 chk("stall_hold_pc", bus.pc_out, 32'h108);
    chk("stall_hold_addr", bus.imem_addr, 32'h10C);
`ifdef FETCH_STALL_CNT_EN
    chk("stall_cnt_delta", stall_cnt - s0, 32'd3);
`endif
    cycle(0, 0, 0, 0, 1);
    #1 chk("drain_valid", {31'd0, bus.out_valid}, 32'd0);

    // Redirect beats a same-cycle ack.
    cycle(1, 32'h200, 0, 1, 1);
    #1 chk("redir_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("redir_addr", bus.imem_addr, 32'h200);
    cycle(0, 0, 0, 1, 1);
    #1 chk("redir_fetch", bus.pc_out, 32'h200);

    // Halt for four cycles; the first cycle's ack is still taken.
    cycle(0, 0, 1, 1, 1);
    #1 chk("halt_ack_pc", bus.pc_out, 32'h204);
    repeat (3) cycle(0, 0, 1, 1, 1);
    #1 chk("halt_pc_hold", bus.imem_addr, 32'h208);
    cycle(0, 0, 0, 1, 1);
    cycle(0, 0, 0, 1, 1);
    #1 chk("resume_pc", bus.pc_out, 32'h208);

    // PC wrap-around.
    cycle(1, 32'hFFFF_FFF8, 0, 0, 1);
    cycle(0, 0, 0, 1, 1);
    cycle(0, 0, 0, 1, 1);
    #1 chk("wrap_pc", bus.pc_out, 32'hFFFF_FFFC);
    chk("wrap_npc", bus.next_pc, 32'h0);
    chk("wrap_addr", bus.imem_addr, 32'h0);
    cycle(0, 0, 0, 1, 1);
    #1 chk("wrap_fetch0", bus.pc_out, 32'h0);

    // Reset while an instruction is held.
    chk("pre_rst_valid", {31'd0, bus.out_valid}, 32'd1);
    do_reset();
    cycle(0, 0, 0, 1, 1);
    cycle(0, 0, 0, 1, 1);
    #1 chk("post_rst_pc", bus.pc_out, RPC);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      r = $urandom;
      r[1:0] = 2'b00;
      if ($urandom_range(0, 7) == 0) r = 32'hFFFF_FFF0;
      if (i == 1500) do_reset();
      cycle($urandom_range(0, 19) == 0, r, $urandom_range(0, 9) == 0,
            $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7);
    end
    @(negedge clk);
    check_all();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
